// File: rtl/au_pkg.sv
// Shared types for the sequential arithmetic unit.
// Optional divider enabled by defining AU_SEQ_DIV_EN.
package au_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

`ifdef AU_SEQ_DIV_EN
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    DIV_RUN = 2'b10
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01
  } state_t;
`endif

  localparam int FLG_COUT = 3;
  localparam int FLG_OVR  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_NEG  = 0;

  function automatic logic [3:0] mk_flags(
    input logic c,
    input logic o,
    input logic z,
    input logic n
  );
    logic [3:0] f;
    f = '0;
    f[FLG_COUT] = c;
    f[FLG_OVR]  = o;
    f[FLG_ZERO] = z;
    f[FLG_NEG]  = n;
    return f;
  endfunction

endpackage

// File: rtl/au_addsub_flags.sv
// Combinational W-bit adder/subtractor with carry, overflow,
// zero and sign flags; shared by ADD/SUB, MUL and DIV steps.
module au_addsub_flags #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovr,
  output logic         zero,
  output logic         neg
);

  logic [W-1:0] bx;

  assign bx = b ^ {W{sub}};
  assign {cout, s} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
  assign ovr  = (a[W-1] == bx[W-1]) & (s[W-1] ^ a[W-1]);
  assign zero = (s == '0);
  assign neg  = s[W-1];

endmodule

// File: rtl/au_seq.sv
// Sequential arithmetic unit: 1-cycle ADD/SUB, W-cycle shift-add MUL.
// Define AU_SEQ_DIV_EN to add W-cycle restoring division on Op=11.
module au_seq
  import au_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic [W-1:0] X,
  input  logic         LoadA,
  input  logic         LoadB,
  input  logic         Start,
  input  logic [1:0]   Op,
  output logic         Busy,
  output logic         Done,
  output logic [W-1:0] Rout,
  output logic [W-1:0] RoutHi,
  output logic [3:0]   Flags
);

  state_t st_q, st_d;
  op_t    op;

  logic [W-1:0]  a_q, b_q;
  logic [W-1:0]  acc_q, mq_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rout_q, routhi_q;
  logic [3:0]    flags_q;
  logic          done_q;
  logic          last;

  logic [W-1:0] as_a, as_s;
  logic         as_sub;
  logic         as_cout, as_ovr, as_zero, as_neg;

  logic [W:0]   mul_sum;
  logic [W-1:0] mul_acc_n, mul_mq_n;

  assign op   = op_t'(Op);
  assign last = (cnt_q == CW'(W - 1));

  au_addsub_flags #(.W(W)) u_as (
    .a    (as_a),
    .b    (b_q),
    .sub  (as_sub),
    .s    (as_s),
    .cout (as_cout),
    .ovr  (as_ovr),
    .zero (as_zero),
    .neg  (as_neg)
  );

  // Add multiplicand when the current multiplier bit is set, then shift.
  assign mul_sum   = mq_q[0] ? {as_cout, as_s} : {1'b0, acc_q};
  assign mul_acc_n = mul_sum[W:1];
  assign mul_mq_n  = {mul_sum[0], mq_q[W-1:1]};

`ifdef AU_SEQ_DIV_EN
  logic [W-1:0] div_low, div_rem_n, div_q_n;
  logic         div_ok;

  // Top remainder bit set means the shifted value already exceeds B.
  assign div_low   = {acc_q[W-2:0], mq_q[W-1]};
  assign div_ok    = acc_q[W-1] | as_cout;
  assign div_rem_n = div_ok ? as_s : div_low;
  assign div_q_n   = {mq_q[W-2:0], div_ok};
`endif

  always_ff @(posedge CLK) begin
    if (!CLR) st_q <= IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d   = st_q;
    as_a   = a_q;
    as_sub = 1'b0;
    unique case (st_q)
      IDLE: begin
        as_sub = (op == OP_SUB);
        if (Start && op == OP_MUL) st_d = MUL_RUN;
`ifdef AU_SEQ_DIV_EN
        if (Start && op == OP_DIV && b_q != '0) st_d = DIV_RUN;
`endif
      end
      MUL_RUN: begin
        as_a = acc_q;
        if (last) st_d = IDLE;
      end
`ifdef AU_SEQ_DIV_EN
      DIV_RUN: begin
        as_a   = div_low;
        as_sub = 1'b1;
        if (last) st_d = IDLE;
      end
`endif
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      cnt_q    <= '0;
      rout_q   <= '0;
      routhi_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          cnt_q <= '0;
          if (LoadA) a_q <= X;
          if (LoadB) b_q <= X;
          if (Start) begin
            unique case (op)
              OP_ADD, OP_SUB: begin
                rout_q   <= as_s;
                routhi_q <= '0;
                flags_q  <= mk_flags(as_cout, as_ovr, as_zero, as_neg);
                done_q   <= 1'b1;
              end
              OP_MUL: begin
                acc_q <= '0;
                mq_q  <= a_q;
              end
              OP_DIV: begin
`ifdef AU_SEQ_DIV_EN
                if (b_q == '0) begin
                  rout_q   <= '1;
                  routhi_q <= a_q;
                  flags_q  <= mk_flags(1'b0, 1'b1, 1'b0, 1'b0);
                  done_q   <= 1'b1;
                end else begin
                  acc_q <= '0;
                  mq_q  <= a_q;
                end
`else
                rout_q   <= '0;
                routhi_q <= '0;
                flags_q  <= mk_flags(1'b0, 1'b1, 1'b1, 1'b0);
                done_q   <= 1'b1;
`endif
              end
              default: ;
            endcase
          end
        end
        MUL_RUN: begin
          acc_q <= mul_acc_n;
          mq_q  <= mul_mq_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            rout_q   <= mul_mq_n;
            routhi_q <= mul_acc_n;
            flags_q  <= mk_flags(|mul_acc_n, |mul_acc_n,
                                 ~|{mul_acc_n, mul_mq_n}, 1'b0);
            done_q   <= 1'b1;
          end
        end
`ifdef AU_SEQ_DIV_EN
        DIV_RUN: begin
          acc_q <= div_rem_n;
          mq_q  <= div_q_n;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            rout_q   <= div_q_n;
            routhi_q <= div_rem_n;
            flags_q  <= mk_flags(1'b0, 1'b0, div_q_n == '0, 1'b0);
            done_q   <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign Busy   = (st_q != IDLE);
  assign Done   = done_q;
  assign Rout   = rout_q;
  assign RoutHi = routhi_q;
  assign Flags  = flags_q;

endmodule

// File: tb/tb_au_seq.sv
// Directed bench for au_seq (W=8); DIV cases when AU_SEQ_DIV_EN is set.
module tb_au_seq;

  logic       CLK = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] X = '0;
  logic       LoadA = 1'b0;
  logic       LoadB = 1'b0;
  logic       Start = 1'b0;
  logic [1:0] Op = 2'b00;
  logic       Busy, Done;
  logic [7:0] Rout, RoutHi;
  logic [3:0] Flags;

  int checks = 0;
  int errors = 0;

  au_seq #(.W(8)) dut (
    .CLK    (CLK),
    .CLR    (CLR),
    .X      (X),
    .LoadA  (LoadA),
    .LoadB  (LoadB),
    .Start  (Start),
    .Op     (Op),
    .Busy   (Busy),
    .Done   (Done),
    .Rout   (Rout),
    .RoutHi (RoutHi),
    .Flags  (Flags)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] va, input logic [7:0] vb);
    X = va; LoadA = 1'b1;
    cyc();
    LoadA = 1'b0; X = vb; LoadB = 1'b1;
    cyc();
    LoadB = 1'b0;
  endtask

  task automatic go(input logic [1:0] o);
    Op = o; Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n;
    int done_n;
    logic [3:0] exp_fl;

    cyc(); cyc();
    CLR = 1'b1;
    chk("rst_rout", Rout, 8'h00);
    chk("rst_routhi", RoutHi, 8'h00);
    chk("rst_flags", Flags, 4'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);

    // ADD 7F+01: overflow into sign bit
    load(8'h7F, 8'h01);
    go(2'b00);
    chk("add_done", Done, 1'b1);
    chk("add_busy", Busy, 1'b0);
    chk("add_rout", Rout, 8'h80);
    chk("add_flags", Flags, 4'b0101);
    cyc();
    chk("add_done_drop", Done, 1'b0);

    // SUB 5-5 with both loads in one cycle
    X = 8'h05; LoadA = 1'b1; LoadB = 1'b1;
    cyc();
    LoadA = 1'b0; LoadB = 1'b0;
    go(2'b01);
    chk("sub0_rout", Rout, 8'h00);
    chk("sub0_routhi", RoutHi, 8'h00);
    chk("sub0_flags", Flags, 4'b1010);

    // SUB 3-5; a B load alongside Start must not affect it
    X = 8'h03; LoadA = 1'b1;
    cyc();
    LoadA = 1'b0;
    X = 8'h00; LoadB = 1'b1;
    go(2'b01);
    LoadB = 1'b0;
    chk("sub1_done", Done, 1'b1);
    chk("sub1_rout", Rout, 8'hFE);
    chk("sub1_flags", Flags, 4'b0001);

    // MUL FF*FF with stray Start/LoadA mid-run
    X = 8'hFF; LoadA = 1'b1; LoadB = 1'b1;
    cyc();
    LoadA = 1'b0; LoadB = 1'b0;
    go(2'b10);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (Busy) busy_n++;
      if (Done) done_n++;
      if (i == 2) begin
        Start = 1'b1; Op = 2'b00; X = 8'h11; LoadA = 1'b1;
      end
      if (i == 3) begin
        Start = 1'b0; LoadA = 1'b0;
        chk("mul_hold_rout", Rout, 8'hFE);
      end
      cyc();
    end
    chk("mul_busy_cycles", busy_n, 8);
    chk("mul_early_done", done_n, 0);
    chk("mul_done", Done, 1'b1);
    chk("mul_busy_fall", Busy, 1'b0);
    chk("mul_routhi", RoutHi, 8'hFE);
    chk("mul_rout", Rout, 8'h01);
    chk("mul_flags", Flags, 4'b1100);
    done_n = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (Done) done_n++;
    end
    chk("mul_no_2nd_done", done_n, 0);

    // A must still be FF: FF+FF
    go(2'b00);
    chk("a_kept_rout", Rout, 8'hFE);
    chk("a_kept_routhi", RoutHi, 8'h00);
    chk("a_kept_flags", Flags, 4'b1001);

    // MUL aborted by reset at Start+4
    load(8'h12, 8'h34);
    go(2'b10);
    cyc(); cyc(); cyc();
    CLR = 1'b0;
    cyc();
    CLR = 1'b1;
    chk("abort_rout", Rout, 8'h00);
    chk("abort_routhi", RoutHi, 8'h00);
    chk("abort_flags", Flags, 4'h0);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (Done || Busy) done_n++;
    end
    chk("abort_quiet", done_n, 0);
    go(2'b00);
    chk("zero_add_done", Done, 1'b1);
    chk("zero_add_flags", Flags, 4'b0010);

`ifdef AU_SEQ_DIV_EN
    // 200/7 = 28 r 4
    load(8'hC8, 8'h07);
    go(2'b11);
    done_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) done_n++;
      cyc();
    end
    chk("div_early_done", done_n, 0);
    chk("div_done", Done, 1'b1);
    chk("div_rout", Rout, 8'h1C);
    chk("div_routhi", RoutHi, 8'h04);
    chk("div_flags", Flags, 4'b0000);
    // divide by zero finishes at once
    load(8'h2A, 8'h00);
    Op = 2'b11; Start = 1'b1;
    cyc();
    chk("div0_done", Done, 1'b1);
    chk("div0_rout", Rout, 8'hFF);
    chk("div0_routhi", RoutHi, 8'h2A);
    chk("div0_flags", Flags, 4'b0100);
    exp_fl = 4'b0000;
`else
    Op = 2'b11; Start = 1'b1;
    cyc();
    chk("ill_done", Done, 1'b1);
    chk("ill_rout", Rout, 8'h00);
    chk("ill_routhi", RoutHi, 8'h00);
    chk("ill_flags", Flags, 4'b0110);
    exp_fl = 4'b0010;
`endif

    // back-to-back: Start held through the Done cycle
    Op = 2'b00;
    cyc();
    Start = 1'b0;
    chk("b2b_done", Done, 1'b1);
    chk("b2b_flags", Flags, exp_fl);
    cyc();
    chk("b2b_done_drop", Done, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
